// File: rtl/cl_dram_dma_pkg.sv
// Shared types and constants for the CL configuration path.
package cl_dram_dma_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Only full-word writes are forwarded to the register block.
    localparam logic [3:0] WSTRB_FULL = 4'hF;

    // States of the AXI-Lite to cfg bus bridge.
    typedef enum logic [2:0] {
        BR_IDLE    = 3'd0,
        BR_WR_REQ  = 3'd1,
        BR_WR_WAIT = 3'd2,
        BR_WR_RESP = 3'd3,
        BR_RD_REQ  = 3'd4,
        BR_RD_WAIT = 3'd5,
        BR_RD_RESP = 3'd6
    } cfg_br_state_t;

endpackage

// File: rtl/cfg_bus_t.sv
// Simple single-outstanding configuration bus between the bridge and CL
// register responders. The bridge drives address, data and strobes through
// the slave modport; responders answer with ack and read data.
interface cfg_bus_t;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic        ack;
    logic [31:0] rdata;

    modport slave  (output addr, output wdata, output wr, output rd,
                    input  ack,  input  rdata);
    modport master (input  addr, input  wdata, input  wr, input  rd,
                    output ack,  output rdata);
endinterface

// File: rtl/cl_axil_cfg_bridge_timer.sv
// Acknowledge watchdog: counts cycles spent waiting for a cfg ack and flags
// when the wait budget is used up. 16-bit saturating counter.
module cfg_ack_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear has priority, otherwise count up and stick at all-ones.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is only meaningful while waiting; the last waiting cycle is TIMEOUT_CYCLES-1.
    assign expired_o = en_i && (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cl_axil_cfg_bridge.sv
// AXI4-Lite slave to cfg bus initiator. One access in flight at a time;
// AW and W are captured independently, reads and writes alternate when both
// are pending, and a watchdog forces SLVERR completion if no ack arrives.
module cl_axil_cfg_bridge
    import cl_dram_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,

    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,

    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,

    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,

    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,

    cfg_bus_t.slave     cfg
);

    cfg_br_state_t state_q, state_d;

    logic        aw_held_q, aw_held_d;
    logic        w_held_q,  w_held_d;
    logic        ar_held_q, ar_held_d;
    logic [31:0] awaddr_q,  awaddr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic [31:0] araddr_q,  araddr_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        last_was_wr_q, last_was_wr_d;
    logic        init_q;

    logic aw_fire, w_fire, ar_fire;
    logic wr_elig, rd_elig;
    logic in_idle, in_wr_cmd, in_rd_cmd;
    logic strb_ok;
    logic timer_clr, timer_en, timer_expired;

    assign in_idle   = (state_q == BR_IDLE);
    assign in_wr_cmd = (state_q == BR_WR_REQ) || (state_q == BR_WR_WAIT);
    assign in_rd_cmd = (state_q == BR_RD_REQ) || (state_q == BR_RD_WAIT);
    assign strb_ok   = (wstrb_q == WSTRB_FULL);

    // Readys stay low during reset and its first cycle out, then open in IDLE
    // for any channel not already holding a captured beat.
    assign s_awready = init_q && in_idle && !aw_held_q;
    assign s_wready  = init_q && in_idle && !w_held_q;
    assign s_arready = init_q && in_idle && !ar_held_q;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid  && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    // A beat arriving this cycle counts toward eligibility so an accepted
    // request reaches the cfg bus on the very next cycle.
    assign wr_elig = (aw_held_q || aw_fire) && (w_held_q || w_fire);
    assign rd_elig = ar_held_q || ar_fire;

    // Response channels.
    assign s_bvalid = (state_q == BR_WR_RESP);
    assign s_bresp  = bresp_q;
    assign s_rvalid = (state_q == BR_RD_RESP);
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;

    // cfg bus: address/data held stable for the whole request/wait window.
    assign cfg.addr  = in_wr_cmd ? awaddr_q : (in_rd_cmd ? araddr_q : 32'h0);
    assign cfg.wdata = in_wr_cmd ? wdata_q  : 32'h0;
    assign cfg.wr    = (state_q == BR_WR_REQ) && strb_ok;
    assign cfg.rd    = (state_q == BR_RD_REQ);

    // The watchdog restarts at each request pulse and runs while waiting.
    assign timer_clr = (state_q == BR_WR_REQ) || (state_q == BR_RD_REQ);
    assign timer_en  = (state_q == BR_WR_WAIT) || (state_q == BR_RD_WAIT);

    cfg_ack_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state, capture and response logic for the bridge FSM.
    always_comb begin
        state_d       = state_q;
        aw_held_d     = aw_held_q;
        w_held_d      = w_held_q;
        ar_held_d     = ar_held_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        araddr_d      = araddr_q;
        bresp_d       = bresp_q;
        rresp_d       = rresp_q;
        rdata_d       = rdata_q;
        last_was_wr_d = last_was_wr_q;

        unique case (state_q)
            BR_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if (ar_fire) begin
                    ar_held_d = 1'b1;
                    araddr_d  = s_araddr;
                end
                // On contention serve the opposite of the last completed kind.
                if (wr_elig && (!rd_elig || !last_was_wr_q)) begin
                    state_d = BR_WR_REQ;
                end else if (rd_elig) begin
                    state_d = BR_RD_REQ;
                end
            end

            BR_WR_REQ: begin
                if (!strb_ok) begin
                    bresp_d = AXI_RESP_SLVERR;
                    state_d = BR_WR_RESP;
                end else if (cfg.ack) begin
                    bresp_d = AXI_RESP_OKAY;
                    state_d = BR_WR_RESP;
                end else begin
                    state_d = BR_WR_WAIT;
                end
            end

            BR_WR_WAIT: begin
                if (cfg.ack) begin
                    bresp_d = AXI_RESP_OKAY;
                    state_d = BR_WR_RESP;
                end else if (timer_expired) begin
                    bresp_d = AXI_RESP_SLVERR;
                    state_d = BR_WR_RESP;
                end
            end

            BR_WR_RESP: begin
                if (s_bready) begin
                    aw_held_d     = 1'b0;
                    w_held_d      = 1'b0;
                    last_was_wr_d = 1'b1;
                    state_d       = BR_IDLE;
                end
            end

            BR_RD_REQ: begin
                if (cfg.ack) begin
                    rresp_d = AXI_RESP_OKAY;
                    rdata_d = cfg.rdata;
                    state_d = BR_RD_RESP;
                end else begin
                    state_d = BR_RD_WAIT;
                end
            end

            BR_RD_WAIT: begin
                if (cfg.ack) begin
                    rresp_d = AXI_RESP_OKAY;
                    rdata_d = cfg.rdata;
                    state_d = BR_RD_RESP;
                end else if (timer_expired) begin
                    rresp_d = AXI_RESP_SLVERR;
                    rdata_d = TIMEOUT_RDATA;
                    state_d = BR_RD_RESP;
                end
            end

            BR_RD_RESP: begin
                if (s_rready) begin
                    ar_held_d     = 1'b0;
                    last_was_wr_d = 1'b0;
                    state_d       = BR_IDLE;
                end
            end

            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: captured payload is reset too so the cfg bus and read data show defined values straight out of reset.
            state_q       <= BR_IDLE;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            ar_held_q     <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            araddr_q      <= '0;
            bresp_q       <= AXI_RESP_OKAY;
            rresp_q       <= AXI_RESP_OKAY;
            rdata_q       <= '0;
            last_was_wr_q <= 1'b0;
            init_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            ar_held_q     <= ar_held_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            araddr_q      <= araddr_d;
            bresp_q       <= bresp_d;
            rresp_q       <= rresp_d;
            rdata_q       <= rdata_d;
            last_was_wr_q <= last_was_wr_d;
            init_q        <= 1'b1;
        end
    end

endmodule
